// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Key map, state encoding and idle patterns.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] ROW_IDLE  = 4'b1110;
  localparam logic [3:0] COL_IDLE  = 4'hF;

  function automatic logic one_low(
    input logic [3:0] c
  );
    case (c)
      4'b1110, 4'b1101,
      4'b1011, 4'b0111: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] col_index(
    input logic [3:0] c
  );
    case (c)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] key_value(
    input logic [1:0] r,
    input logic [1:0] c
  );
    unique case ({r, c})
      4'd0:  return 4'h1;
      4'd1:  return 4'h2;
      4'd2:  return 4'h3;
      4'd3:  return 4'hA;
      4'd4:  return 4'h4;
      4'd5:  return 4'h5;
      4'd6:  return 4'h6;
      4'd7:  return 4'hB;
      4'd8:  return 4'h7;
      4'd9:  return 4'h8;
      4'd10: return 4'h9;
      4'd11: return 4'hC;
      4'd12: return 4'hE;
      4'd13: return 4'h0;
      4'd14: return 4'hF;
      4'd15: return 4'hD;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins and key-event outputs.
// master = scanner, slave = keypad/consumer side.
interface keypad_scanner_if;

  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_pressed;
  logic [23:0] data_bcd;

  modport master (
    input  col,
    output row,
    output key_code,
    output key_valid,
    output key_pressed,
    output data_bcd
  );

  modport slave (
    output col,
    input  row,
    input  key_code,
    input  key_valid,
    input  key_pressed,
    input  data_bcd
  );

endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Generic two-flop synchronizer for async inputs.
// Reset value is a parameter so idle-high lines stay idle.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce
// and a 6-digit BCD entry shift register.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_CYCLES    = 50000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input logic            clk,
  input logic            rst_n,
  keypad_scanner_if.master bus
);

  localparam int SW =
    (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [SW-1:0] SC_LAST =
    SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_TICKS - 1);

  logic [SW-1:0] scan_cnt;
  logic          tick;
  logic [3:0]    col_s;
  logic [3:0]    key;
  logic [7:0]    row_rot;
  logic          accept;

  state_t        state, state_n;
  logic [1:0]    row_idx, row_idx_n;
  logic [DW-1:0] db_cnt, db_cnt_n;
  logic [3:0]    lat_col, lat_col_n;
  logic [3:0]    key_code, key_code_n;
  logic          key_valid, key_valid_n;
  logic          key_pressed, key_pressed_n;
  logic [23:0]   data_bcd, data_bcd_n;

  sync_2ff #(
    .WIDTH   (4),
    .RST_VAL (COL_IDLE)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.col),
    .q     (col_s)
  );

  // free-running row dwell counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else if (scan_cnt == SC_LAST) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  assign tick = (scan_cnt == SC_LAST);
  assign key  = key_value(row_idx, col_index(col_s));

  // next-state, debounce and key-accept logic
  always_comb begin
    state_n       = state;
    row_idx_n     = row_idx;
    db_cnt_n      = db_cnt;
    lat_col_n     = lat_col;
    key_code_n    = key_code;
    key_valid_n   = 1'b0;
    key_pressed_n = key_pressed;
    data_bcd_n    = data_bcd;
    accept        = 1'b0;
    unique case (state)
      SCAN: begin
        if (tick) begin
          if (one_low(col_s)) begin
            lat_col_n = col_s;
            db_cnt_n  = DW'(1);
            if (DEBOUNCE_TICKS == 1) begin
              accept = 1'b1;
            end else begin
              state_n = PRESS_DB;
            end
          end else begin
            row_idx_n = row_idx + 2'd1;
          end
        end
      end
      PRESS_DB: begin
        if (tick) begin
          if (col_s == lat_col) begin
            db_cnt_n = db_cnt + DW'(1);
            if (db_cnt == DB_LAST) begin
              accept = 1'b1;
            end
          end else begin
            state_n   = SCAN;
            row_idx_n = row_idx + 2'd1;
          end
        end
      end
      HELD: begin
        if (tick && col_s == COL_IDLE) begin
          if (DEBOUNCE_TICKS == 1) begin
            state_n       = SCAN;
            key_pressed_n = 1'b0;
            row_idx_n     = row_idx + 2'd1;
          end else begin
            db_cnt_n = DW'(1);
            state_n  = RELEASE_DB;
          end
        end
      end
      RELEASE_DB: begin
        if (tick) begin
          if (col_s == COL_IDLE) begin
            db_cnt_n = db_cnt + DW'(1);
            if (db_cnt == DB_LAST) begin
              state_n       = SCAN;
              key_pressed_n = 1'b0;
              row_idx_n     = row_idx + 2'd1;
            end
          end else begin
            state_n = HELD;
          end
        end
      end
    endcase
    if (accept) begin
      state_n       = HELD;
      key_valid_n   = 1'b1;
      key_code_n    = key;
      key_pressed_n = 1'b1;
      if (key <= 4'd9) begin
        data_bcd_n = {data_bcd[19:0], key};
      end else if (key == KEY_CLEAR) begin
        data_bcd_n = '0;
      end
    end
  end

  // scanner state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SCAN;
      row_idx     <= 2'd0;
      db_cnt      <= '0;
      lat_col     <= COL_IDLE;
      key_code    <= 4'h0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
      data_bcd    <= '0;
    end else begin
      state       <= state_n;
      row_idx     <= row_idx_n;
      db_cnt      <= db_cnt_n;
      lat_col     <= lat_col_n;
      key_code    <= key_code_n;
      key_valid   <= key_valid_n;
      key_pressed <= key_pressed_n;
      data_bcd    <= data_bcd_n;
    end
  end

  assign row_rot         = {ROW_IDLE, ROW_IDLE} << row_idx;
  assign bus.row         = row_rot[7:4];
  assign bus.key_code    = key_code;
  assign bus.key_valid   = key_valid;
  assign bus.key_pressed = key_pressed;
  assign bus.data_bcd    = data_bcd;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model,
// per-cycle reference model and directed scenarios.
module tb_keypad_scanner;

  localparam int SC = 4;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] keys = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  int kmap [16] = '{1, 2, 3, 10, 4, 5, 6, 11,
                    7, 8, 9, 12, 14, 0, 15, 13};

  keypad_scanner_if bus ();

  keypad_scanner #(
    .SCAN_CYCLES    (SC),
    .DEBOUNCE_TICKS (DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // keypad: a pressed key shorts its column to its row
  always_comb begin
    bus.col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !bus.row[r]) bus.col[c] = 1'b0;
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // reference model: sample counting per tick
  int m_sc = 0, m_row = 0, m_n = 0;
  bit m_valid = 0, m_pressed = 0;
  logic [3:0] m_code = 0, m_pat = 4'hF;
  logic [3:0] h1 = 4'hF, h2 = 4'hF;
  logic [23:0] m_bcd = 0;

  always @(posedge clk) begin : mdl
    logic [3:0] s;
    bit tk;
    int ci, code;
    if (!rst_n) begin
      m_sc = 0; m_row = 0; m_n = 0;
      m_valid = 0; m_pressed = 0;
      m_code = 0; m_bcd = 0;
      h1 = 4'hF; h2 = 4'hF;
    end else begin
      s = h2; h2 = h1; h1 = bus.col;
      tk = (m_sc == SC - 1);
      m_sc = (m_sc + 1) % SC;
      m_valid = 0;
      if (tk && !m_pressed) begin
        if (m_n == 0) begin
          if ($countones(~s) == 1) begin
            m_pat = s; m_n = 1;
          end else m_row = (m_row + 1) % 4;
        end else if (s == m_pat) m_n++;
        else begin
          m_n = 0; m_row = (m_row + 1) % 4;
        end
        if (m_n == DB) begin
          ci = 0;
          for (int i = 0; i < 4; i++)
            if (!s[i]) ci = i;
          code = kmap[m_row*4+ci];
          m_code = 4'(code);
          m_valid = 1; m_pressed = 1; m_n = 0;
          if (code < 10)
            m_bcd = {m_bcd[19:0], 4'(code)};
          else if (code == 12) m_bcd = 0;
        end
      end else if (tk) begin
        if (s == 4'hF) m_n++;
        else m_n = 0;
        if (m_n == DB) begin
          m_pressed = 0; m_n = 0;
          m_row = (m_row + 1) % 4;
        end
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("row", bus.row,
            4'hF ^ (4'h1 << m_row));
      check("key_valid", bus.key_valid, m_valid);
      check("key_code", bus.key_code, m_code);
      check("key_pressed", bus.key_pressed, m_pressed);
      check("data_bcd", bus.data_bcd, m_bcd);
      if (bus.key_valid) pulses++;
    end
  end

  task automatic wait_valid(input string nm);
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      got = bus.key_valid;
    end
    check({nm, " accept"}, got, 1);
  endtask

  task automatic wait_release(input string nm);
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      got = !bus.key_pressed;
    end
    check({nm, " release"}, got, 1);
  endtask

  task automatic wait_row_start(input logic [3:0] p);
    bit got = 0;
    logic [3:0] prev = bus.row;
    for (int i = 0; i < 64 && !got; i++) begin
      @(posedge clk); #1;
      got = (bus.row == p) && (prev != p);
      prev = bus.row;
    end
    check("row start", got, 1);
  endtask

  task automatic press_key(input int idx,
                           input string nm);
    int p0 = pulses;
    keys[idx] = 1'b1;
    wait_valid(nm);
    repeat (20) @(posedge clk);
    #1;
    check({nm, " pulses"}, pulses - p0, 1);
    check({nm, " held"}, bus.key_pressed, 1);
    keys[idx] = 1'b0;
    wait_release(nm);
    repeat (6) @(posedge clk);
    #1;
  endtask

  int typed [7] = '{0, 1, 2, 4, 5, 6, 8};
  int p0;

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst row", bus.row, 4'b1110);
    check("rst valid", bus.key_valid, 0);
    check("rst pressed", bus.key_pressed, 0);
    check("rst bcd", bus.data_bcd, 24'h0);
    check("rst code", bus.key_code, 4'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rot1", bus.row, 4'b1101);
    repeat (4) @(posedge clk);
    #1;
    check("rot2", bus.row, 4'b1011);
    repeat (4) @(posedge clk);
    #1;
    check("rot3", bus.row, 4'b0111);
    repeat (4) @(posedge clk);
    #1;
    check("rot0", bus.row, 4'b1110);

    press_key(5, "key5");
    check("k5 code", bus.key_code, 4'h5);
    check("k5 bcd", bus.data_bcd, 24'h000005);

    foreach (typed[i])
      press_key(typed[i], $sformatf("type%0d", i + 1));
    check("typed bcd", bus.data_bcd, 24'h234567);
    press_key(11, "keyC");
    check("C bcd", bus.data_bcd, 24'h0);
    check("C code", bus.key_code, 4'hC);

    p0 = pulses;
    wait_row_start(4'b1011);
    keys[10] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    keys[10] = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("bounce9 pulses", pulses - p0, 0);
    check("bounce9 pressed", bus.key_pressed, 0);
    wait_row_start(4'b1110);

    p0 = pulses;
    keys[7] = 1'b1;
    wait_valid("keyB");
    keys[7] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    keys[7] = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    check("relbounce pulses", pulses - p0, 1);
    check("relbounce held", bus.key_pressed, 1);
    check("B code", bus.key_code, 4'hB);
    keys[7] = 1'b0;
    wait_release("keyB");

    p0 = pulses;
    keys[0] = 1'b1;
    keys[2] = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("multi pulses", pulses - p0, 0);
    keys = '0;
    repeat (8) @(posedge clk);

    p0 = pulses;
    keys[0] = 1'b1;
    wait_valid("key1");
    keys[3] = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("A ignored", pulses - p0, 1);
    check("1 code", bus.key_code, 4'h1);
    check("1 bcd", bus.data_bcd, 24'h000001);
    keys = '0;
    wait_release("key1");

    press_key(11, "keyC2");
    p0 = pulses;
    wait_row_start(4'b1101);
    keys[5] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid rst row", bus.row, 4'b1110);
    check("mid rst valid", bus.key_valid, 0);
    check("mid rst pressed", bus.key_pressed, 0);
    check("mid rst bcd", bus.data_bcd, 24'h0);
    keys = '0;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("mid rst pulses", pulses - p0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 active-low matrix keypad: drives one row low at a time, samples the columns, debounces, and reports one key event per press. It is the input-side counterpart of the multiplexed seven-segment display driver. It also keeps a 6-digit BCD entry register (data_bcd) that connects directly to the display driver's data_bcd input, so typed digits show on the display.

Parameters:
SCAN_CYCLES, 50000, clocks per row dwell (1 ms at 50 MHz); must be >= 4
DEBOUNCE_TICKS, 20, consecutive matching row-samples required for press and for release; must be >= 1

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
col  input  4  keypad columns, active-low, asynchronous (external pull-ups)
row  output  4  keypad row drive, active-low, one-hot-low
key_code  output  4  keypad value of last accepted key (see map)
key_valid  output  1  one-cycle pulse when a debounced press is accepted
key_pressed  output  1  level, high while an accepted key is held
data_bcd  output  24  6-digit BCD entry, digit 0 = [3:0]

Behaviour:
- Reset (rst_n low at posedge clk): row=4'b1110, row_idx=0, scan_cnt=0, state=SCAN, key_code=0, key_valid=0, key_pressed=0, data_bcd=0, sync flops=4'hF, debounce counter=0.
- col passes through a 2-FF synchronizer (col_s). All decisions use col_s.
- scan_cnt counts 0..SCAN_CYCLES-1 and then wraps. "tick" = the cycle with scan_cnt==SCAN_CYCLES-1. Samples are taken only on ticks.
- Map from {row_idx,col_idx} to key value: row0: 1 2 3 A; row1: 4 5 6 B; row2: 7 8 9 C; row3: E 0 F D. col_idx = position of the single low column bit (bit0 = col 0).
- Valid sample = col_s has exactly one bit low. Zero or multiple bits low = no key (multi-key is rejected).
- FSM:
  - SCAN: on tick, if the sample is valid, latch row_idx/col_s, set db_cnt=1, go to PRESS_DB and keep the current row. Otherwise rotate row to the next one (0->1->2->3->0). If DEBOUNCE_TICKS==1, go straight to the press-accept action below instead.
  - PRESS_DB: row held. On tick, if col_s equals the latched pattern, db_cnt++. When db_cnt reaches DEBOUNCE_TICKS, accept the press. On mismatch, go to SCAN and rotate row.
  - Accept press: next cycle key_valid=1 for exactly 1 cycle, key_code is updated, key_pressed=1, state=HELD. In the same cycle data_bcd updates:
    - value 0-9: data_bcd <= {data_bcd[19:0], value}. The oldest digit is dropped on overflow.
    - value C: data_bcd <= 0.
    - any other value: data_bcd is unchanged.
  - HELD: on tick, if col_s==4'hF, set db_cnt=1 and go to RELEASE_DB (or straight to SCAN if DEBOUNCE_TICKS==1).
  - RELEASE_DB: on tick, if col_s==4'hF, db_cnt++. When db_cnt reaches DEBOUNCE_TICKS, go to SCAN, key_pressed=0, rotate row. On any tick with col_s!=4'hF, return to HELD.
- key_code holds its value until the next accepted press. key_valid is never asserted twice for one physical press.
- Rows are never rotated outside SCAN. A second key pressed while a key is held is ignored until full release.
- Reset mid-operation returns to reset values on the next clk edge. No key_valid is emitted on reset.

Decomposition:
- Shared package: FSM state enum (SCAN, PRESS_DB, HELD, RELEASE_DB), key value map function/table, constants KEY_CLEAR=4'hC and ROW_IDLE=4'b1110.
- One natural sub-module: sync_2ff (generic 2-flop synchronizer, width parameter), reused for other asynchronous inputs.

Test Plan (SCAN_CYCLES=4, DEBOUNCE_TICKS=3; keypad model pulls col low when its row is low):
- Reset: rst_n low for 2 clocks -> row=4'b1110, key_valid=0, key_pressed=0, data_bcd=24'h0. With no key, row rotates 1110->1101->1011->0111 every 4 clocks.
- Press "5" (row1,col1) held stable -> exactly one key_valid pulse, key_code=4'h5, data_bcd=24'h000005, key_pressed high until 3 released ticks after let-go.
- Type 1,2,3,4,5,6,7 -> data_bcd=24'h234567 (overflow drops the 1). Then press C -> data_bcd=24'h0 and key_code=4'hC.
- Bounce: key "9" present for 2 ticks, then absent -> no key_valid and scan resumes. Release bounce (col returns low after 1 released tick) -> stays HELD with no second key_valid.
- Two keys in the same row (cols 0 and 2 low) -> no key_valid. Press "A" while "1" is held -> ignored, no key_valid.
- Reset asserted in PRESS_DB mid-debounce -> state SCAN, row=4'b1110, no key_valid, data_bcd unchanged from 0.
